// File: rtl/burst_mem_pkg.sv
// Shared types and beat address arithmetic for the burst memory controller.
package burst_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_e;

    // Address of beat idx. The result is left unmasked; callers keep only the
    // low ADDR_WIDTH bits, which gives the silent INCR wrap at the top of memory.
    function automatic logic [31:0] next_beat_addr(
        input logic [31:0] base,
        input logic [31:0] idx,
        input logic [31:0] len,
        input burst_type_e btype
    );
        logic [31:0] wrap_mask;
        logic [31:0] result;
        wrap_mask = len;  // len+1 is a power of two for legal WRAP, so L-1 == len
        case (btype)
            FIXED:   result = base;
            INCR:    result = base + idx;
            WRAP:    result = (base & ~wrap_mask) | ((base + idx) & wrap_mask);
            default: result = base;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/burst_mem_ctrl_sp_ram.sv
// Single-port RAM: synchronous write, registered read with one cycle latency.
// Only the read register is reset; the array contents are not.
module sp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Registered read port, holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/burst_mem_ctrl.sv
// Burst memory controller: accepts one FIXED/INCR/WRAP burst at a time,
// generates beat addresses internally and fronts an integrated sp_ram.
module burst_mem_ctrl
    import burst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  req_err,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    burst_type_e           btype_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  req_err_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;

    logic [LEN_WIDTH:0]    len_p1;
    logic                  len_pow2;
    logic                  req_legal;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  ram_we;
    logic                  ram_re;

    // Request legality: reserved type, or WRAP whose length is 1 or not a power of two
    always_comb begin
        len_p1    = (LEN_WIDTH+1)'(req_len) + (LEN_WIDTH+1)'(1);
        len_pow2  = ((len_p1 & (LEN_WIDTH+1)'(req_len)) == '0);
        req_legal = 1'b1;
        if (burst_type_e'(req_type) == RSVD)
            req_legal = 1'b0;
        else if (burst_type_e'(req_type) == WRAP && (req_len == '0 || !len_pow2))
            req_legal = 1'b0;
    end

    // Beat address and RAM port controls for the current beat index
    always_comb begin
        beat_addr = ADDR_WIDTH'(next_beat_addr(32'(base_q), 32'(cnt_q), 32'(len_q), btype_q));
        last_beat = (cnt_q == len_q);
        ram_we    = (state_q == WR_BURST) && wr_valid;
        ram_re    = (state_q == RD_BURST);
    end

    // Controller FSM, beat counter and read valid/last pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            btype_q    <= FIXED;
            cnt_q      <= '0;
            req_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            req_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            base_q  <= req_addr;
                            len_q   <= req_len;
                            btype_q <= burst_type_e'(req_type);
                            cnt_q   <= '0;
                            state_q <= req_write ? WR_BURST : RD_BURST;
                        end else begin
                            req_err_q <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_valid) begin
                        if (last_beat) state_q <= IDLE;
                        else           cnt_q   <= cnt_q + LEN_WIDTH'(1);
                    end
                end
                RD_BURST: begin
                    rd_valid_q <= 1'b1;
                    rd_last_q  <= last_beat;
                    if (last_beat) state_q <= IDLE;
                    else           cnt_q   <= cnt_q + LEN_WIDTH'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (beat_addr),
        .wdata (wr_data),
        .rdata (rd_data)
    );

    // Status outputs decoded from the state register; req_ready is held low during reset
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        busy      = (state_q != IDLE);
        wr_ready  = (state_q == WR_BURST);
        req_err   = req_err_q;
        rd_valid  = rd_valid_q;
        rd_last   = rd_last_q;
    end

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Self-checking bench for burst_mem_ctrl: directed cases plus random bursts
// checked against an array-based memory model.
module tb_burst_mem_ctrl;
    import burst_mem_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int MB    = 16;
    localparam int LW    = 4;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_type;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          req_err;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [DEPTH];

    burst_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_err   (req_err),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat address from the burst rules using modular arithmetic
    function automatic int model_addr(input int base, input int i, input int len, input int t);
        int l;
        l = len + 1;
        case (t)
            0:       return base;
            1:       return (base + i) % DEPTH;
            default: return base - (base % l) + ((base + i) % l);
        endcase
    endfunction

    function automatic bit model_legal(input int t, input int len);
        int l;
        l = len + 1;
        if (t == 3) return 1'b0;
        if (t == 2) return (l == 2 || l == 4 || l == 8 || l == 16);
        return 1'b1;
    endfunction

    // Present a request at a negedge; returns one cycle after the accept edge
    task automatic send_req(input bit w, input int t, input int a, input int l, output bit legal);
        legal = model_legal(t, l);
        check_val("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = w;
        req_type  = 2'(t);
        req_addr  = 8'(a);
        req_len   = 4'(l);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("req_err", req_err, legal ? 0 : 1);
        check_val("busy_after_req", busy, legal ? 1 : 0);
        if (!legal) begin
            @(negedge clk);
            check_val("req_err_pulse", req_err, 0);
            check_val("busy_after_err", busy, 0);
        end
    endtask

    // dmode 0: random data, otherwise data = dstart + beat
    task automatic do_write(input int t, input int a, input int l, input int stall_pct,
                            input int dmode, input int dstart);
        bit legal;
        int done;
        int cyc;
        bit v;
        logic [7:0] d;
        send_req(1'b1, t, a, l, legal);
        if (!legal) return;
        done = 0;
        cyc  = 0;
        while (done <= l && cyc < 400) begin
            check_val("wr_ready_burst", wr_ready, 1);
            check_val("req_ready_in_wr", req_ready, 0);
            v = ($urandom_range(99) >= stall_pct);
            d = (dmode != 0) ? 8'(dstart + done) : 8'($urandom_range(255));
            wr_valid = v;
            wr_data  = d;
            @(negedge clk);
            if (v) begin
                model_mem[model_addr(a, done, l, t)] = d;
                done++;
            end
            cyc++;
        end
        wr_valid = 1'b0;
        check_val("wr_beats", done, l + 1);
        check_val("req_ready_after_wr", req_ready, 1);
        check_val("busy_after_wr", busy, 0);
        check_val("wr_ready_idle", wr_ready, 0);
    endtask

    task automatic do_read(input int t, input int a, input int l);
        bit legal;
        send_req(1'b0, t, a, l, legal);
        if (!legal) return;
        check_val("rd_valid_issue_cycle", rd_valid, 0);
        for (int b = 0; b <= l; b++) begin
            @(negedge clk);
            check_val("rd_valid", rd_valid, 1);
            check_val("rd_data", rd_data, model_mem[model_addr(a, b, l, t)]);
            check_val("rd_last", rd_last, (b == l) ? 1 : 0);
            check_val("req_ready_rd", req_ready, (b == l) ? 1 : 0);
        end
        @(negedge clk);
        check_val("rd_valid_after", rd_valid, 0);
    endtask

    initial begin
        bit legal;
        int t;
        int l;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_type  = 2'd0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;

        repeat (3) @(negedge clk);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_req_err", req_err, 0);
        check_val("rst_wr_ready", wr_ready, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_data", rd_data, 0);
        check_val("rst_rd_last", rd_last, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check_val("req_ready_after_rst", req_ready, 1);
        @(negedge clk);

        // Ramp preload: mem[k] = k
        for (int k = 0; k < DEPTH; k += 16) do_write(1, k, 15, 0, 1, k);

        do_read(2, 8'h0E, 3);
        do_write(1, 8'h10, 3, 0, 1, 8'hA0);
        do_read(1, 8'h10, 3);
        do_write(0, 8'h20, 3, 0, 1, 1);
        do_read(0, 8'h20, 0);
        do_write(1, 8'hFE, 3, 0, 1, 8'h55);
        do_read(1, 8'hFE, 3);
        do_read(1, 8'hF0, 15);

        send_req(1'b1, 2, 8'h30, 2, legal);
        send_req(1'b1, 3, 8'h30, 3, legal);
        do_read(1, 8'h30, 3);

        do_write(1, 8'h60, 7, 50, 0, 0);
        do_read(1, 8'h60, 7);

        for (int n = 0; n < 40; n++) begin
            t = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
            if (t == 2 && $urandom_range(3) != 0) l = (1 << $urandom_range(4, 1)) - 1;
            else l = int'($urandom_range(15));
            if ($urandom_range(1) == 1) do_write(t, int'($urandom_range(255)), l, 30, 0, 0);
            else                        do_read(t, int'($urandom_range(255)), l);
        end

        // Reset in the middle of a read burst
        send_req(1'b0, 1, 8'h40, 15, legal);
        repeat (3) @(negedge clk);
        check_val("rd_valid_before_rst", rd_valid, 1);
        rst = 1'b1;
        #1;
        check_val("midrst_rd_valid", rd_valid, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_req_err", req_err, 0);
        check_val("midrst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("req_ready_after_midrst", req_ready, 1);
        check_val("busy_after_midrst", busy, 0);
        @(negedge clk);
        do_read(1, 8'h40, 15);
        do_read(1, 8'h10, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
